// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//    Shares one single-cycle-latency memory port between a fetch requester
//    and a data requester. The data side normally wins a collision. A 2-bit
//    starvation counter hands the port to fetch after three data grants in a
//    row that were made while fetch was waiting. Read data returns the cycle
//    after the grant and is steered to the owner of that grant.
//
// Ports
//    clk      : clock, all state changes on posedge
//    reset    : synchronous, active-high reset
//    f_req    : fetch request (held until granted)
//    f_addr   : fetch byte address
//    f_gnt    : fetch request accepted this cycle
//    f_rvalid : fetch read data valid (1-cycle pulse)
//    f_rdata  : fetch read data (0 when not valid)
//    d_req    : data request (held until granted)
//    d_addr   : data byte address
//    d_wdata  : store data
//    d_we     : byte write enables, 0 means load
//    d_gnt    : data request accepted this cycle
//    d_rvalid : load data valid / store acknowledge (1-cycle pulse)
//    d_rdata  : load data (0 when not valid)
//    m_addr   : shared memory address
//    m_wdata  : shared memory write data
//    m_we     : shared memory byte write enables
//    m_rdata  : shared memory read data, valid one cycle after the address
module mem_port_arbiter (
   input  logic        clk,
   input  logic        reset,
   input  logic        f_req,
   input  logic [31:0] f_addr,
   output logic        f_gnt,
   output logic        f_rvalid,
   output logic [31:0] f_rdata,
   input  logic        d_req,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_we,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   output logic [3:0]  m_we,
   input  logic [31:0] m_rdata
);

   localparam logic [1:0] OWN_NONE  = 2'd0;
   localparam logic [1:0] OWN_FETCH = 2'd1;
   localparam logic [1:0] OWN_DATA  = 2'd2;

   localparam logic [1:0] STARVE_MAX = 2'd3;

   logic [1:0] owner_r;
   logic [1:0] starve_cnt_r;
   logic       f_gnt_s;
   logic       d_gnt_s;
   logic       starve_s;

   // Grant selection: data wins unless fetch has been starved three times.
   always_comb begin
      starve_s = 1'b0;
      f_gnt_s  = 1'b0;
      d_gnt_s  = 1'b0;
      if (reset) begin
         starve_s = 1'b0;
         f_gnt_s  = 1'b0;
         d_gnt_s  = 1'b0;
      end else begin
         starve_s = f_req && (starve_cnt_r == STARVE_MAX);
         d_gnt_s  = d_req && !starve_s;
         f_gnt_s  = f_req && !d_gnt_s;
      end
   end

   assign f_gnt = f_gnt_s;
   assign d_gnt = d_gnt_s;

   // Memory request mux: only the granted side reaches the port, else all zero.
   always_comb begin
      m_addr  = 32'd0;
      m_wdata = 32'd0;
      m_we    = 4'd0;
      if (d_gnt_s) begin
         m_addr  = d_addr;
         m_wdata = d_wdata;
         m_we    = d_we;
      end else if (f_gnt_s) begin
         m_addr  = f_addr;
         m_wdata = 32'd0;
         m_we    = 4'd0;
      end else begin
         m_addr  = 32'd0;
         m_wdata = 32'd0;
         m_we    = 4'd0;
      end
   end

   // Owner of the previous cycle's grant, used to steer the response.
   always_ff @(posedge clk) begin
      if (reset) begin
         owner_r <= OWN_NONE;
      end else if (f_gnt_s) begin
         owner_r <= OWN_FETCH;
      end else if (d_gnt_s) begin
         owner_r <= OWN_DATA;
      end else begin
         owner_r <= OWN_NONE;
      end
   end

   // Starvation counter: counts data grants taken while fetch waits.
   always_ff @(posedge clk) begin
      if (reset) begin
         starve_cnt_r <= 2'd0;
      end else if (f_gnt_s || !f_req) begin
         starve_cnt_r <= 2'd0;
      end else if (d_gnt_s && (starve_cnt_r != STARVE_MAX)) begin
         starve_cnt_r <= starve_cnt_r + 2'd1;
      end else begin
         starve_cnt_r <= starve_cnt_r;
      end
   end

   // Response steering. Gated by reset so a grant made just before reset
   // asserts never produces a response.
   always_comb begin
      f_rvalid = 1'b0;
      f_rdata  = 32'd0;
      d_rvalid = 1'b0;
      d_rdata  = 32'd0;
      if (reset) begin
         f_rvalid = 1'b0;
         d_rvalid = 1'b0;
      end else begin
         case (owner_r)
            OWN_FETCH: begin
               f_rvalid = 1'b1;
               f_rdata  = m_rdata;
            end
            OWN_DATA: begin
               d_rvalid = 1'b1;
               d_rdata  = m_rdata;
            end
            default: begin
               f_rvalid = 1'b0;
               d_rvalid = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//    Directed bench for mem_port_arbiter. Inputs change just after each
//    posedge, outputs are sampled 1 time unit later, well away from the edge.
module tb_mem_port_arbiter;

   logic        clk;
   logic        reset;
   logic        f_req;
   logic [31:0] f_addr;
   logic        f_gnt;
   logic        f_rvalid;
   logic [31:0] f_rdata;
   logic        d_req;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [3:0]  d_we;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [3:0]  m_we;
   logic [31:0] m_rdata;

   int checks_r;
   int failures_r;

   mem_port_arbiter dut (
      .clk      (clk),
      .reset    (reset),
      .f_req    (f_req),
      .f_addr   (f_addr),
      .f_gnt    (f_gnt),
      .f_rvalid (f_rvalid),
      .f_rdata  (f_rdata),
      .d_req    (d_req),
      .d_addr   (d_addr),
      .d_wdata  (d_wdata),
      .d_we     (d_we),
      .d_gnt    (d_gnt),
      .d_rvalid (d_rvalid),
      .d_rdata  (d_rdata),
      .m_addr   (m_addr),
      .m_wdata  (m_wdata),
      .m_we     (m_we),
      .m_rdata  (m_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks_r = checks_r + 1;
      if (got !== exp) begin
         failures_r = failures_r + 1;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance one cycle and settle just after the edge.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   logic [4:0] starve_exp_d;

   initial begin
      checks_r     = 0;
      failures_r   = 0;
      starve_exp_d = 5'b10111;

      reset   = 1'b1;
      f_req   = 1'b1;
      f_addr  = 32'h0000_0044;
      d_req   = 1'b1;
      d_addr  = 32'h0000_0088;
      d_wdata = 32'h5555_AAAA;
      d_we    = 4'hF;
      m_rdata = 32'h0000_0000;
      #1;
      // Reset forces grants and the memory port to zero despite requests.
      check_val("rst_f_gnt",   32'(f_gnt), 32'd0);
      check_val("rst_d_gnt",   32'(d_gnt), 32'd0);
      check_val("rst_m_we",    32'(m_we), 32'd0);
      check_val("rst_m_addr",  m_addr, 32'd0);
      check_val("rst_m_wdata", m_wdata, 32'd0);
      next_cycle();
      reset = 1'b0;
      f_req = 1'b0;
      d_req = 1'b0;
      d_we  = 4'h0;
      #1;
      check_val("post_rst_f_rvalid", 32'(f_rvalid), 32'd0);
      check_val("post_rst_d_rvalid", 32'(d_rvalid), 32'd0);
      check_val("idle_m_addr", m_addr, 32'd0);

      // Lone fetch.
      next_cycle();
      f_req  = 1'b1;
      f_addr = 32'h0000_0010;
      #1;
      check_val("lone_f_gnt",  32'(f_gnt), 32'd1);
      check_val("lone_d_gnt",  32'(d_gnt), 32'd0);
      check_val("lone_m_addr", m_addr, 32'h0000_0010);
      check_val("lone_m_we",   32'(m_we), 32'd0);
      next_cycle();
      f_req   = 1'b0;
      m_rdata = 32'hDEAD_BEEF;
      #1;
      check_val("lone_f_rvalid", 32'(f_rvalid), 32'd1);
      check_val("lone_f_rdata",  f_rdata, 32'hDEAD_BEEF);
      check_val("lone_d_rvalid", 32'(d_rvalid), 32'd0);
      check_val("lone_d_rdata",  d_rdata, 32'd0);

      // Collision: data wins, fetch follows.
      next_cycle();
      f_req  = 1'b1;
      f_addr = 32'h0000_0020;
      d_req  = 1'b1;
      d_addr = 32'h0000_0080;
      d_we   = 4'h0;
      #1;
      check_val("col_d_gnt",  32'(d_gnt), 32'd1);
      check_val("col_f_gnt",  32'(f_gnt), 32'd0);
      check_val("col_m_addr", m_addr, 32'h0000_0080);
      next_cycle();
      d_req   = 1'b0;
      m_rdata = 32'hCAFE_0001;
      #1;
      check_val("col2_f_gnt",    32'(f_gnt), 32'd1);
      check_val("col2_m_addr",   m_addr, 32'h0000_0020);
      check_val("col2_d_rvalid", 32'(d_rvalid), 32'd1);
      check_val("col2_d_rdata",  d_rdata, 32'hCAFE_0001);
      check_val("col2_f_rvalid", 32'(f_rvalid), 32'd0);
      check_val("col2_f_rdata",  f_rdata, 32'd0);
      next_cycle();
      f_req   = 1'b0;
      m_rdata = 32'h1111_2222;
      #1;
      check_val("col3_f_rvalid", 32'(f_rvalid), 32'd1);
      check_val("col3_f_rdata",  f_rdata, 32'h1111_2222);
      check_val("col3_d_rvalid", 32'(d_rvalid), 32'd0);

      // Store.
      next_cycle();
      d_req   = 1'b1;
      d_addr  = 32'h0000_0040;
      d_wdata = 32'h0000_1234;
      d_we    = 4'b0011;
      #1;
      check_val("st_d_gnt",   32'(d_gnt), 32'd1);
      check_val("st_m_we",    32'(m_we), 32'h3);
      check_val("st_m_wdata", m_wdata, 32'h0000_1234);
      check_val("st_m_addr",  m_addr, 32'h0000_0040);
      next_cycle();
      d_req   = 1'b0;
      d_we    = 4'h0;
      d_wdata = 32'h0000_0000;
      #1;
      check_val("st_d_rvalid", 32'(d_rvalid), 32'd1);
      check_val("st_f_rvalid", 32'(f_rvalid), 32'd0);
      check_val("st_idle_m_we", 32'(m_we), 32'd0);

      // Starvation: both held for five cycles -> D,D,D,F,D.
      for (int i = 0; i < 5; i++) begin
         next_cycle();
         f_req  = 1'b1;
         f_addr = 32'h0000_0100;
         d_req  = 1'b1;
         d_addr = 32'h0000_0200;
         #1;
         check_val($sformatf("starve%0d_d_gnt", i), 32'(d_gnt), 32'(starve_exp_d[i]));
         check_val($sformatf("starve%0d_f_gnt", i), 32'(f_gnt), 32'(!starve_exp_d[i]));
      end
      next_cycle();
      f_req = 1'b0;
      d_req = 1'b0;
      #1;
      check_val("starve_end_d_rvalid", 32'(d_rvalid), 32'd1);

      // Back-to-back fetches at 0x0 and 0x4.
      next_cycle();
      f_req  = 1'b1;
      f_addr = 32'h0000_0000;
      #1;
      check_val("b2b0_f_gnt",  32'(f_gnt), 32'd1);
      check_val("b2b0_m_addr", m_addr, 32'h0000_0000);
      next_cycle();
      f_addr  = 32'h0000_0004;
      m_rdata = 32'hA0A0_A0A0;
      #1;
      check_val("b2b1_f_gnt",    32'(f_gnt), 32'd1);
      check_val("b2b1_m_addr",   m_addr, 32'h0000_0004);
      check_val("b2b1_f_rvalid", 32'(f_rvalid), 32'd1);
      check_val("b2b1_f_rdata",  f_rdata, 32'hA0A0_A0A0);
      next_cycle();
      f_req   = 1'b0;
      m_rdata = 32'hB0B0_B0B0;
      #1;
      check_val("b2b2_f_rvalid", 32'(f_rvalid), 32'd1);
      check_val("b2b2_f_rdata",  f_rdata, 32'hB0B0_B0B0);
      next_cycle();
      check_val("b2b3_f_rvalid", 32'(f_rvalid), 32'd0);

      // Reset right after a data grant: no response may appear.
      d_req  = 1'b1;
      d_addr = 32'h0000_0100;
      #1;
      check_val("rmid_d_gnt", 32'(d_gnt), 32'd1);
      next_cycle();
      reset = 1'b1;
      f_req = 1'b1;
      #1;
      check_val("rmid1_d_rvalid", 32'(d_rvalid), 32'd0);
      check_val("rmid1_d_gnt",    32'(d_gnt), 32'd0);
      check_val("rmid1_f_gnt",    32'(f_gnt), 32'd0);
      check_val("rmid1_m_we",     32'(m_we), 32'd0);
      next_cycle();
      reset = 1'b0;
      f_req = 1'b0;
      d_req = 1'b0;
      #1;
      check_val("rmid2_d_rvalid", 32'(d_rvalid), 32'd0);
      check_val("rmid2_f_rvalid", 32'(f_rvalid), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
      $finish;
   end

endmodule
